// File: rtl/ram_bist_seq_pkg.sv
// Shared types and constants for the RAM burst self-test sequencer.
package ram_bist_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_REQ     = 3'd1,
        ST_WR_DATA    = 3'd2,
        ST_GAP        = 3'd3,
        ST_RD_REQ     = 3'd4,
        ST_RD_COLLECT = 3'd5,
        ST_FINISH     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PAT_ADDR    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_WALK    = 2'd2,
        PAT_INV     = 2'd3
    } pat_e;

    localparam logic [15:0] BSEL_CONST = 16'h0001;
    localparam int          GAP_CYCLES = 2;

endpackage

// File: rtl/ram_bist_seq_if.sv
// Burst write/read RAM port bundle driven by the self-test sequencer.
interface ram_bist_seq_if;
    logic        RAM_WR_REQ;
    logic        RAM_WR_DVLD;
    logic        RAM_WR_SOP;
    logic        RAM_WR_EOP;
    logic [15:0] RAM_WR_ADDR;
    logic [15:0] RAM_WR_SIZE;
    logic [15:0] RAM_WR_BSEL;
    logic [63:0] RAM_WR_DATA;
    logic        RAM_RD_REQ;
    logic        RAM_RD_RDY;
    logic [15:0] RAM_RD_ADDR;
    logic [15:0] RAM_RD_SIZE;
    logic [15:0] RAM_RD_BSEL;
    logic        RAM_RD_SOP;
    logic        RAM_RD_EOP;
    logic        RAM_RD_DVLD;
    logic [63:0] RAM_RD_DATA;

    modport master (
        output RAM_WR_REQ, RAM_WR_DVLD, RAM_WR_SOP, RAM_WR_EOP,
        output RAM_WR_ADDR, RAM_WR_SIZE, RAM_WR_BSEL, RAM_WR_DATA,
        output RAM_RD_REQ, RAM_RD_RDY, RAM_RD_ADDR, RAM_RD_SIZE, RAM_RD_BSEL,
        input  RAM_RD_SOP, RAM_RD_EOP, RAM_RD_DVLD, RAM_RD_DATA
    );

    modport slave (
        input  RAM_WR_REQ, RAM_WR_DVLD, RAM_WR_SOP, RAM_WR_EOP,
        input  RAM_WR_ADDR, RAM_WR_SIZE, RAM_WR_BSEL, RAM_WR_DATA,
        input  RAM_RD_REQ, RAM_RD_RDY, RAM_RD_ADDR, RAM_RD_SIZE, RAM_RD_BSEL,
        output RAM_RD_SOP, RAM_RD_EOP, RAM_RD_DVLD, RAM_RD_DATA
    );
endinterface

// File: rtl/ram_bist_patgen.sv
// Test word generator: pattern select, burst base address and word index to 64-bit data.
module ram_bist_patgen
    import ram_bist_seq_pkg::*;
(
    input  pat_e        pattern,
    input  logic [7:0]  base,
    input  logic [7:0]  idx,
    output logic [63:0] data
);
    logic [7:0] addr_s;

    assign addr_s = base + idx;

    // Word for the selected pattern; address-derived patterns use the wrapped address
    always_comb begin
        data = 64'h0;
        case (pattern)
            PAT_ADDR:    data = {8{addr_s}};
            PAT_CHECKER: data = idx[0] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
            PAT_WALK:    data = 64'h1 << idx[5:0];
            PAT_INV:     data = ~{8{addr_s}};
            default:     data = 64'h0;
        endcase
    end
endmodule

// File: rtl/ram_bist_seq.sv
// RAM burst self-test: writes one patterned burst, reads it back and scores the result.
module ram_bist_seq
    import ram_bist_seq_pkg::*;
#(
    parameter int BURST_WORDS = 32,
    parameter int RD_TIMEOUT  = 16
) (
    input  logic        USER_CLK,
    input  logic        USER_RST,
    input  logic        START,
    input  logic [7:0]  BASE_ADDR,
    input  logic [1:0]  PATTERN,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic        TIMEOUT,
    output logic [15:0] ERR_CNT,
    output logic [7:0]  FIRST_ERR_IDX,
    ram_bist_seq_if.master ram
);
    localparam logic [7:0]  LAST_IDX   = 8'(BURST_WORDS - 1);
    localparam logic [15:0] BURST_SIZE = 16'(BURST_WORDS * 8);
    localparam logic [15:0] TO_LAST    = 16'(RD_TIMEOUT - 1);
    localparam logic [1:0]  GAP_LAST   = 2'(GAP_CYCLES - 1);

    state_e      state_r, state_nxt;
    pat_e        pat_r, pat_nxt;
    logic [7:0]  base_r, base_nxt;
    logic [7:0]  wr_idx_r, wr_idx_nxt;
    logic [7:0]  rd_idx_r, rd_idx_nxt;
    logic [1:0]  gap_cnt_r, gap_nxt;
    logic [15:0] idle_cnt_r, idle_nxt;
    logic [15:0] err_cnt_r, err_nxt;
    logic [7:0]  first_err_r, first_nxt;
    logic        timeout_r, timeout_nxt;
    logic        pass_r, pass_nxt;

    logic        busy_r, done_r;
    logic        wr_req_r, wr_dvld_r, wr_sop_r, wr_eop_r, rd_req_r, rd_rdy_r;
    logic [15:0] wr_addr_r, wr_size_r, rd_addr_r, rd_size_r;
    logic [63:0] wr_data_r;

    logic [63:0] wr_pat_s, cmp_pat_s;
    logic        mism_s, sop_bad_s, eop_bad_s;
    logic [1:0]  err_inc_s;
    logic [16:0] err_sum_s;
    logic [15:0] err_sat_s;

    ram_bist_patgen u_wr_pat (.pattern(pat_nxt), .base(base_nxt), .idx(wr_idx_nxt), .data(wr_pat_s));
    ram_bist_patgen u_cmp_pat (.pattern(pat_r), .base(base_r), .idx(rd_idx_r), .data(cmp_pat_s));

    assign mism_s    = (ram.RAM_RD_DATA != cmp_pat_s);
    assign sop_bad_s = (rd_idx_r == 8'd0) && !ram.RAM_RD_SOP;
    assign eop_bad_s = (rd_idx_r == LAST_IDX) && !ram.RAM_RD_EOP;
    assign err_inc_s = {1'b0, mism_s} + {1'b0, sop_bad_s} + {1'b0, eop_bad_s};
    assign err_sum_s = {1'b0, err_cnt_r} + {15'd0, err_inc_s};
    assign err_sat_s = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];

    // Next-state, burst counters and result statistics
    always_comb begin
        state_nxt   = state_r;
        pat_nxt     = pat_r;
        base_nxt    = base_r;
        wr_idx_nxt  = wr_idx_r;
        rd_idx_nxt  = rd_idx_r;
        gap_nxt     = gap_cnt_r;
        idle_nxt    = idle_cnt_r;
        err_nxt     = err_cnt_r;
        first_nxt   = first_err_r;
        timeout_nxt = timeout_r;
        pass_nxt    = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt   = ST_WR_REQ;
                    base_nxt    = BASE_ADDR;
                    pat_nxt     = pat_e'(PATTERN);
                    err_nxt     = 16'd0;
                    first_nxt   = 8'd0;
                    timeout_nxt = 1'b0;
                    pass_nxt    = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                state_nxt  = ST_WR_DATA;
                wr_idx_nxt = 8'd0;
            end
            ST_WR_DATA: begin
                if (wr_idx_r == LAST_IDX) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = 2'd0;
                end else begin
                    wr_idx_nxt = wr_idx_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt = ST_RD_REQ;
                end else begin
                    gap_nxt = gap_cnt_r + 2'd1;
                end
            end
            ST_RD_REQ: begin
                state_nxt  = ST_RD_COLLECT;
                rd_idx_nxt = 8'd0;
                idle_nxt   = 16'd0;
            end
            ST_RD_COLLECT: begin
                if (ram.RAM_RD_DVLD) begin
                    idle_nxt = 16'd0;
                    if (err_inc_s != 2'd0) begin
                        err_nxt = err_sat_s;
                        // A zero count means this is the first failing word of the run
                        if (err_cnt_r == 16'd0) begin
                            first_nxt = rd_idx_r;
                        end else begin
                            first_nxt = first_err_r;
                        end
                    end else begin
                        err_nxt = err_cnt_r;
                    end
                    if (rd_idx_r == LAST_IDX) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        rd_idx_nxt = rd_idx_r + 8'd1;
                    end
                end else if (idle_cnt_r == TO_LAST) begin
                    state_nxt   = ST_FINISH;
                    timeout_nxt = 1'b1;
                end else begin
                    idle_nxt = idle_cnt_r + 16'd1;
                end
                if (state_nxt == ST_FINISH) begin
                    pass_nxt = (err_nxt == 16'd0) && !timeout_nxt;
                end else begin
                    pass_nxt = 1'b0;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, captured run parameters and statistics
    always_ff @(posedge USER_CLK) begin
        if (USER_RST) begin
            state_r     <= ST_IDLE;
            pat_r       <= PAT_ADDR;
            base_r      <= 8'd0;
            wr_idx_r    <= 8'd0;
            rd_idx_r    <= 8'd0;
            gap_cnt_r   <= 2'd0;
            idle_cnt_r  <= 16'd0;
            err_cnt_r   <= 16'd0;
            first_err_r <= 8'd0;
            timeout_r   <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            pat_r       <= pat_nxt;
            base_r      <= base_nxt;
            wr_idx_r    <= wr_idx_nxt;
            rd_idx_r    <= rd_idx_nxt;
            gap_cnt_r   <= gap_nxt;
            idle_cnt_r  <= idle_nxt;
            err_cnt_r   <= err_nxt;
            first_err_r <= first_nxt;
            timeout_r   <= timeout_nxt;
            pass_r      <= pass_nxt;
        end
    end

    // Output strobes are decoded from the next state so they line up with state_r
    always_ff @(posedge USER_CLK) begin
        if (USER_RST) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_req_r  <= 1'b0;
            wr_dvld_r <= 1'b0;
            wr_sop_r  <= 1'b0;
            wr_eop_r  <= 1'b0;
            wr_addr_r <= 16'd0;
            wr_size_r <= 16'd0;
            wr_data_r <= 64'd0;
            rd_req_r  <= 1'b0;
            rd_addr_r <= 16'd0;
            rd_size_r <= 16'd0;
            rd_rdy_r  <= 1'b1;
        end else begin
            busy_r    <= (state_nxt != ST_IDLE);
            done_r    <= (state_nxt == ST_FINISH);
            wr_req_r  <= (state_nxt == ST_WR_REQ);
            wr_dvld_r <= (state_nxt == ST_WR_DATA);
            wr_sop_r  <= (state_nxt == ST_WR_DATA) && (wr_idx_nxt == 8'd0);
            wr_eop_r  <= (state_nxt == ST_WR_DATA) && (wr_idx_nxt == LAST_IDX);
            wr_addr_r <= (state_nxt == ST_WR_REQ) ? {8'h00, base_nxt} : 16'd0;
            wr_size_r <= (state_nxt == ST_WR_REQ) ? BURST_SIZE : 16'd0;
            wr_data_r <= (state_nxt == ST_WR_DATA) ? wr_pat_s : 64'd0;
            rd_req_r  <= (state_nxt == ST_RD_REQ);
            rd_addr_r <= (state_nxt == ST_RD_REQ) ? {8'h00, base_nxt} : 16'd0;
            rd_size_r <= ((state_nxt == ST_RD_REQ) || (state_nxt == ST_RD_COLLECT) ||
                          (state_nxt == ST_FINISH)) ? BURST_SIZE : 16'd0;
            rd_rdy_r  <= 1'b1;
        end
    end

    assign BUSY            = busy_r;
    assign DONE            = done_r;
    assign PASS            = pass_r;
    assign TIMEOUT         = timeout_r;
    assign ERR_CNT         = err_cnt_r;
    assign FIRST_ERR_IDX   = first_err_r;
    assign ram.RAM_WR_REQ  = wr_req_r;
    assign ram.RAM_WR_DVLD = wr_dvld_r;
    assign ram.RAM_WR_SOP  = wr_sop_r;
    assign ram.RAM_WR_EOP  = wr_eop_r;
    assign ram.RAM_WR_ADDR = wr_addr_r;
    assign ram.RAM_WR_SIZE = wr_size_r;
    assign ram.RAM_WR_BSEL = BSEL_CONST;
    assign ram.RAM_WR_DATA = wr_data_r;
    assign ram.RAM_RD_REQ  = rd_req_r;
    assign ram.RAM_RD_RDY  = rd_rdy_r;
    assign ram.RAM_RD_ADDR = rd_addr_r;
    assign ram.RAM_RD_SIZE = rd_size_r;
    assign ram.RAM_RD_BSEL = BSEL_CONST;
endmodule

// File: tb/tb_ram_bist_seq.sv
// Bench for ram_bist_seq: behavioural RAM with 3-cycle read latency plus write scoreboard.
module tb_ram_bist_seq;
    localparam int N  = 4;
    localparam int TO = 16;

    logic        USER_CLK = 1'b0;
    logic        USER_RST;
    logic        START;
    logic [7:0]  BASE_ADDR;
    logic [1:0]  PATTERN;
    logic        BUSY, DONE, PASS, TIMEOUT;
    logic [15:0] ERR_CNT;
    logic [7:0]  FIRST_ERR_IDX;

    ram_bist_seq_if ram_if ();

    ram_bist_seq #(.BURST_WORDS(N), .RD_TIMEOUT(TO)) dut (
        .USER_CLK(USER_CLK), .USER_RST(USER_RST), .START(START),
        .BASE_ADDR(BASE_ADDR), .PATTERN(PATTERN),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMEOUT(TIMEOUT),
        .ERR_CNT(ERR_CNT), .FIRST_ERR_IDX(FIRST_ERR_IDX), .ram(ram_if)
    );

    always #5 USER_CLK = ~USER_CLK;

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } wr_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    wr_exp_t     wr_q[$];
    logic [63:0] mem [256];
    bit          rd_flip_23 = 1'b0;
    bit          rd_mute = 1'b0;
    int          wr_req_cyc = 0;
    int          rd_req_cyc = 0;
    logic [15:0] wr_size_seen = 16'd0;
    logic [15:0] rd_size_seen = 16'd0;

    function automatic logic [63:0] model_word(int pat, logic [7:0] base, int i);
        logic [7:0] a;
        a = base + 8'(i);
        case (pat)
            0:       return 64'h0101_0101_0101_0101 * {56'd0, a};
            1:       return ((i % 2) == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
            2:       return 64'h1 << (i % 64);
            default: return ~(64'h0101_0101_0101_0101 * {56'd0, a});
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge USER_CLK);
            cyc++;
        end
    end

    // RAM model: scoreboards every written word and replays reads 3 cycles after RD_REQ
    initial begin : ram_model
        logic [7:0]  wr_ptr;
        logic [7:0]  rd_ptr;
        logic [63:0] d;
        wr_exp_t     e;
        wr_exp_t     got;
        int          rd_wait, rd_left, rd_j, rd_total;
        wr_ptr = 8'd0; rd_ptr = 8'd0; rd_wait = 0; rd_left = 0; rd_j = 0; rd_total = 0;
        forever begin
            @(posedge USER_CLK);
            #1;
            if (USER_RST) begin
                rd_left = 0;
                rd_wait = 0;
                ram_if.RAM_RD_DVLD = 1'b0; ram_if.RAM_RD_SOP = 1'b0;
                ram_if.RAM_RD_EOP = 1'b0;  ram_if.RAM_RD_DATA = 64'd0;
            end else begin
                if (ram_if.RAM_WR_REQ) begin
                    wr_req_cyc   = cyc;
                    wr_size_seen = ram_if.RAM_WR_SIZE;
                    wr_ptr       = ram_if.RAM_WR_ADDR[7:0];
                end
                if (ram_if.RAM_WR_DVLD) begin
                    got = '{addr: wr_ptr, data: ram_if.RAM_WR_DATA,
                            sop: ram_if.RAM_WR_SOP, eop: ram_if.RAM_WR_EOP};
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL wr_extra: got addr=%h data=%h, required no write", got.addr, got.data);
                    end else begin
                        e = wr_q.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL wr_word: got addr=%h data=%h sop=%b eop=%b, required addr=%h data=%h sop=%b eop=%b",
                                     got.addr, got.data, got.sop, got.eop, e.addr, e.data, e.sop, e.eop);
                        end
                    end
                    mem[wr_ptr] = ram_if.RAM_WR_DATA;
                    wr_ptr = wr_ptr + 8'd1;
                end
                if (rd_left > 0 && rd_wait == 0) begin
                    d = mem[rd_ptr];
                    if (rd_flip_23 && (rd_j == 2 || rd_j == 3)) d[0] = ~d[0];
                    ram_if.RAM_RD_DVLD = 1'b1;
                    ram_if.RAM_RD_SOP  = (rd_j == 0);
                    ram_if.RAM_RD_EOP  = (rd_j == rd_total - 1);
                    ram_if.RAM_RD_DATA = d;
                    rd_ptr = rd_ptr + 8'd1;
                    rd_j++;
                    rd_left--;
                end else begin
                    ram_if.RAM_RD_DVLD = 1'b0; ram_if.RAM_RD_SOP = 1'b0;
                    ram_if.RAM_RD_EOP = 1'b0;  ram_if.RAM_RD_DATA = 64'd0;
                end
                if (rd_wait > 0) rd_wait--;
                if (ram_if.RAM_RD_REQ) begin
                    rd_req_cyc   = cyc;
                    rd_size_seen = ram_if.RAM_RD_SIZE;
                    rd_ptr       = ram_if.RAM_RD_ADDR[7:0];
                    rd_total     = int'(ram_if.RAM_RD_SIZE) / 8;
                    rd_left      = rd_mute ? 0 : rd_total;
                    rd_wait      = 2;
                    rd_j         = 0;
                end
            end
        end
    end

    task automatic launch(input logic [7:0] base, input logic [1:0] pat, output int t0);
        @(posedge USER_CLK);
        #1;
        BASE_ADDR = base;
        PATTERN   = pat;
        START     = 1'b1;
        t0        = cyc;
        for (int i = 0; i < N; i++) begin
            wr_q.push_back('{addr: base + 8'(i), data: model_word(int'(pat), base, i),
                             sop: (i == 0), eop: (i == N - 1)});
        end
        @(posedge USER_CLK);
        #1;
        START     = 1'b0;
        BASE_ADDR = 8'h00;
        PATTERN   = ~pat;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(posedge USER_CLK);
            #1;
            if (DONE) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL done_wait: DONE not seen within 80 cycles");
        end
    endtask

    task automatic test_reset;
        USER_RST = 1'b1;
        repeat (3) @(posedge USER_CLK);
        #1;
        checks++;
        if ({BUSY, DONE, PASS, TIMEOUT} !== 4'b0000) begin
            errors++; $display("FAIL rst_status: got %b, required 0000", {BUSY, DONE, PASS, TIMEOUT});
        end
        checks++;
        if ({ERR_CNT, FIRST_ERR_IDX} !== 24'd0) begin
            errors++; $display("FAIL rst_stats: got err=%h first=%h, required 0", ERR_CNT, FIRST_ERR_IDX);
        end
        checks++;
        if ({ram_if.RAM_WR_REQ, ram_if.RAM_WR_DVLD, ram_if.RAM_RD_REQ, ram_if.RAM_RD_RDY} !== 4'b0001) begin
            errors++; $display("FAIL rst_strobes: got wr_req/dvld/rd_req/rdy=%b, required 0001",
                               {ram_if.RAM_WR_REQ, ram_if.RAM_WR_DVLD, ram_if.RAM_RD_REQ, ram_if.RAM_RD_RDY});
        end
        START = 1'b1;
        BASE_ADDR = 8'h77;
        @(posedge USER_CLK);
        #1;
        USER_RST = 1'b0;
        START = 1'b0;
        repeat (2) @(posedge USER_CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_start_ignored: got BUSY=%b, required 0", BUSY);
        end
    endtask

    task automatic test_basic;
        int t0, lat;
        launch(8'h10, 2'd0, t0);
        checks++;
        if ({BUSY, ram_if.RAM_WR_REQ} !== 2'b11 || ram_if.RAM_WR_ADDR !== 16'h0010) begin
            errors++; $display("FAIL basic_wr_req: got busy=%b req=%b addr=%h, required 1 1 0010",
                               BUSY, ram_if.RAM_WR_REQ, ram_if.RAM_WR_ADDR);
        end
        wait_done(t0, lat);
        checks++;
        if (lat != 2 * N + 7) begin
            errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, 2 * N + 7);
        end
        checks++;
        if ({PASS, TIMEOUT} !== 2'b10 || ERR_CNT !== 16'd0) begin
            errors++; $display("FAIL basic_result: got pass=%b to=%b err=%0d, required 1 0 0", PASS, TIMEOUT, ERR_CNT);
        end
        checks++;
        if (wr_req_cyc - t0 != 1 || rd_req_cyc - t0 != N + 4) begin
            errors++; $display("FAIL basic_req_cycles: got wr=%0d rd=%0d, required 1 %0d",
                               wr_req_cyc - t0, rd_req_cyc - t0, N + 4);
        end
        checks++;
        if (wr_size_seen !== 16'(N * 8) || rd_size_seen !== 16'(N * 8)) begin
            errors++; $display("FAIL basic_size: got wr=%0d rd=%0d, required %0d", wr_size_seen, rd_size_seen, N * 8);
        end
        @(posedge USER_CLK);
        #1;
        checks++;
        if ({DONE, BUSY, PASS} !== 3'b001 || wr_q.size() != 0) begin
            errors++; $display("FAIL basic_after: got done=%b busy=%b pass=%b pending=%0d, required 0 0 1 0",
                               DONE, BUSY, PASS, wr_q.size());
        end
    endtask

    task automatic test_wrap;
        int t0, lat;
        launch(8'hFE, 2'd2, t0);
        wait_done(t0, lat);
        checks++;
        if (lat != 2 * N + 7 || PASS !== 1'b1 || wr_q.size() != 0) begin
            errors++; $display("FAIL wrap_result: got lat=%0d pass=%b pending=%0d, required %0d 1 0",
                               lat, PASS, wr_q.size(), 2 * N + 7);
        end
        checks++;
        if (mem[8'hFF] !== 64'h2 || mem[8'h01] !== 64'h8) begin
            errors++; $display("FAIL wrap_mem: got FF=%h 01=%h, required 2 8", mem[8'hFF], mem[8'h01]);
        end
    endtask

    task automatic test_patterns;
        int t0, lat;
        for (int p = 1; p < 4; p += 2) begin
            launch(8'h40, 2'(p), t0);
            wait_done(t0, lat);
            checks++;
            if (PASS !== 1'b1 || ERR_CNT !== 16'd0 || wr_q.size() != 0) begin
                errors++; $display("FAIL pattern%0d: got pass=%b err=%0d pending=%0d, required 1 0 0",
                                   p, PASS, ERR_CNT, wr_q.size());
            end
        end
    endtask

    task automatic test_bitflip;
        int t0, lat;
        rd_flip_23 = 1'b1;
        launch(8'h20, 2'd0, t0);
        wait_done(t0, lat);
        rd_flip_23 = 1'b0;
        checks++;
        if (ERR_CNT !== 16'd2 || FIRST_ERR_IDX !== 8'd2) begin
            errors++; $display("FAIL flip_stats: got err=%0d first=%0d, required 2 2", ERR_CNT, FIRST_ERR_IDX);
        end
        checks++;
        if ({PASS, TIMEOUT} !== 2'b00 || lat != 2 * N + 7) begin
            errors++; $display("FAIL flip_result: got pass=%b to=%b lat=%0d, required 0 0 %0d",
                               PASS, TIMEOUT, lat, 2 * N + 7);
        end
    endtask

    task automatic test_timeout;
        int t0, lat;
        rd_mute = 1'b1;
        launch(8'h60, 2'd1, t0);
        checks++;
        if (ERR_CNT !== 16'd0 || FIRST_ERR_IDX !== 8'd0) begin
            errors++; $display("FAIL to_cleared: got err=%0d first=%0d, required 0 0", ERR_CNT, FIRST_ERR_IDX);
        end
        wait_done(t0, lat);
        rd_mute = 1'b0;
        checks++;
        if (lat != N + 5 + TO) begin
            errors++; $display("FAIL to_latency: got %0d, required %0d", lat, N + 5 + TO);
        end
        checks++;
        if ({TIMEOUT, PASS} !== 2'b10) begin
            errors++; $display("FAIL to_flags: got to=%b pass=%b, required 1 0", TIMEOUT, PASS);
        end
        repeat (3) @(posedge USER_CLK);
        #1;
        checks++;
        if ({TIMEOUT, DONE, BUSY} !== 3'b100) begin
            errors++; $display("FAIL to_hold: got to=%b done=%b busy=%b, required 1 0 0", TIMEOUT, DONE, BUSY);
        end
    endtask

    task automatic test_reset_mid;
        int t0, t1, lat;
        launch(8'h30, 2'd3, t0);
        @(posedge USER_CLK);
        #1;
        checks++;
        if (ram_if.RAM_WR_DVLD !== 1'b1) begin
            errors++; $display("FAIL mid_in_burst: got WR_DVLD=%b, required 1", ram_if.RAM_WR_DVLD);
        end
        USER_RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge USER_CLK);
            #1;
            checks++;
            if ({BUSY, ram_if.RAM_WR_DVLD, ram_if.RAM_WR_SOP, ram_if.RAM_WR_EOP, ram_if.RAM_RD_REQ} !== 5'b0 ||
                ram_if.RAM_WR_DATA !== 64'd0 || ram_if.RAM_RD_RDY !== 1'b1) begin
                errors++; $display("FAIL mid_rst_outputs: got busy=%b dvld=%b data=%h rdy=%b, required 0 0 0 1",
                                   BUSY, ram_if.RAM_WR_DVLD, ram_if.RAM_WR_DATA, ram_if.RAM_RD_RDY);
            end
        end
        USER_RST = 1'b0;
        wr_q.delete();
        launch(8'h50, 2'd0, t1);
        repeat (3) @(posedge USER_CLK);
        #1;
        START = 1'b1;
        BASE_ADDR = 8'h99;
        PATTERN = 2'd2;
        @(posedge USER_CLK);
        #1;
        START = 1'b0;
        wait_done(t1, lat);
        checks++;
        if (lat != 2 * N + 7 || PASS !== 1'b1 || wr_q.size() != 0) begin
            errors++; $display("FAIL mid_fresh_run: got lat=%0d pass=%b pending=%0d, required %0d 1 0",
                               lat, PASS, wr_q.size(), 2 * N + 7);
        end
        repeat (4) @(posedge USER_CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: got BUSY=%b, required 0", BUSY);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        USER_RST = 1'b1;
        START = 1'b0;
        BASE_ADDR = 8'h00;
        PATTERN = 2'd0;
        ram_if.RAM_RD_DVLD = 1'b0;
        ram_if.RAM_RD_SOP = 1'b0;
        ram_if.RAM_RD_EOP = 1'b0;
        ram_if.RAM_RD_DATA = 64'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_patterns();
        test_bitflip();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
